// File: rtl/control_cursa.sv
// ============================================================================
// Module   : control_cursa
// Brief    : Race sequencer for the line-follower car. It handles start-up,
//            the soft-start duty ramp, debounced lap counting, the timed
//            brake and the race-done state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_cursa #(
    parameter int          DEBOUNCE_CYC = 5000,
    parameter int          RAMP_DIV     = 1000,
    parameter logic [11:0] RAMP_STEP    = 12'h010,
    parameter logic [11:0] DC_MAX       = 12'h999,
    parameter int          BRAKE_CYC    = 50000,
    parameter int          TURE_C1      = 2,
    parameter int          TURE_C2      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_senzor_1,
    input  logic        i_senzor_2,
    input  logic        i_senzor_4,
    input  logic        i_senzor_5,
    input  logic [1:0]  i_circuit,
    input  logic        i_start,
    input  logic [1:0]  i_directie_in_A,
    input  logic [1:0]  i_directie_in_B,
    input  logic        i_stop_in,
    output logic [1:0]  o_directie_driverA,
    output logic [1:0]  o_directie_driverB,
    output logic [11:0] o_factor_dc_driverA,
    output logic [11:0] o_factor_dc_driverB,
    output logic [7:0]  o_count_ture,
    output logic        o_tact_count,
    output logic        o_stop,
    output logic        o_cursa_terminata
);

    localparam int TMR_MAX = (RAMP_DIV > BRAKE_CYC) ? RAMP_DIV : BRAKE_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int DW      = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [TW-1:0] C_RAMP_LAST  = TW'(RAMP_DIV - 1);
    localparam logic [TW-1:0] C_BRAKE_LAST = TW'(BRAKE_CYC - 1);
    localparam logic [DW-1:0] C_DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        BRAKE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [DW-1:0]   r_deb_cnt;
    logic            r_armed;
    logic [11:0]     r_duty;
    logic [7:0]      r_count;
    logic            r_tact;
    logic            r_stop;
    logic            r_done;

    logic            w_linie;
    logic            w_run_en;
    logic            w_target_met;
    logic [12:0]     w_duty_sum;
    logic [11:0]     w_duty_next;

    assign w_linie     = i_senzor_1 & i_senzor_2 & i_senzor_4 & i_senzor_5;
    assign w_run_en    = (r_state == RAMP) || (r_state == RUN);
    assign w_duty_sum  = {1'b0, r_duty} + {1'b0, RAMP_STEP};
    assign w_duty_next = (w_duty_sum >= {1'b0, DC_MAX}) ? DC_MAX : w_duty_sum[11:0];

    // Target follows the live circuit code so a mid-race change re-evaluates it.
    always_comb begin
        w_target_met = 1'b0;
        case (i_circuit)
            2'b01:   w_target_met = (r_count >= 8'(TURE_C1));
            2'b10:   w_target_met = (r_count >= 8'(TURE_C2));
            default: w_target_met = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_deb_cnt <= '0;
            r_armed   <= 1'b1;
            r_duty    <= '0;
            r_count   <= '0;
            r_tact    <= 1'b0;
            r_stop    <= 1'b1;
            r_done    <= 1'b0;
        end else if (i_circuit == 2'b00) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_deb_cnt <= '0;
            r_armed   <= 1'b1;
            r_duty    <= '0;
            r_count   <= '0;
            r_tact    <= 1'b0;
            r_stop    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_tact <= 1'b0;

            // Armed: wait for a held line. Disarmed: wait for a held absence.
            if (w_run_en) begin
                if (r_armed == w_linie) begin
                    if (r_deb_cnt == C_DEB_LAST) begin
                        r_deb_cnt <= '0;
                        r_armed   <= ~r_armed;
                        if (r_armed) begin
                            r_tact <= 1'b1;
                            if (r_count != 8'hFF)
                                r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
            end else begin
                r_deb_cnt <= '0;
            end

            case (r_state)
                IDLE: begin
                    r_duty  <= '0;
                    r_stop  <= 1'b1;
                    r_timer <= '0;
                    if (i_start) begin
                        r_state <= RAMP;
                        r_stop  <= i_stop_in;
                    end
                end
                RAMP: begin
                    r_stop <= i_stop_in;
                    if (w_target_met) begin
                        r_state <= BRAKE;
                        r_duty  <= '0;
                        r_stop  <= 1'b1;
                        r_timer <= '0;
                    end else if (r_timer == C_RAMP_LAST) begin
                        r_timer <= '0;
                        r_duty  <= w_duty_next;
                        if (w_duty_next == DC_MAX)
                            r_state <= RUN;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RUN: begin
                    r_stop <= i_stop_in;
                    r_duty <= DC_MAX;
                    if (w_target_met) begin
                        r_state <= BRAKE;
                        r_duty  <= '0;
                        r_stop  <= 1'b1;
                        r_timer <= '0;
                    end
                end
                BRAKE: begin
                    r_duty <= '0;
                    r_stop <= 1'b1;
                    if (r_timer == C_BRAKE_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DONE: begin
                    r_duty <= '0;
                    r_stop <= 1'b1;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_directie_driverA  = w_run_en ? i_directie_in_A : 2'b00;
    assign o_directie_driverB  = w_run_en ? i_directie_in_B : 2'b00;
    assign o_factor_dc_driverA = r_duty;
    assign o_factor_dc_driverB = r_duty;
    assign o_count_ture        = r_count;
    assign o_tact_count        = r_tact;
    assign o_stop              = r_stop;
    assign o_cursa_terminata   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_control_cursa.sv
// ============================================================================
// Module   : tb_control_cursa
// Brief    : Directed scoreboard bench for control_cursa with reduced timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_control_cursa;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        linie = 1'b0;
    logic [1:0]  circuit = 2'b00;
    logic        start = 1'b0;
    logic [1:0]  dir_a = 2'b01;
    logic [1:0]  dir_b = 2'b10;
    logic        stop_in = 1'b0;
    logic [1:0]  o_dir_a, o_dir_b;
    logic [11:0] o_dc_a, o_dc_b;
    logic [7:0]  o_count;
    logic        o_tact, o_stop, o_done;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [11:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    control_cursa #(
        .DEBOUNCE_CYC (4),
        .RAMP_DIV     (2),
        .RAMP_STEP    (12'h400),
        .DC_MAX       (12'hC00),
        .BRAKE_CYC    (8),
        .TURE_C1      (2),
        .TURE_C2      (11)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_senzor_1          (linie),
        .i_senzor_2          (linie),
        .i_senzor_4          (linie),
        .i_senzor_5          (linie),
        .i_circuit           (circuit),
        .i_start             (start),
        .i_directie_in_A     (dir_a),
        .i_directie_in_B     (dir_b),
        .i_stop_in           (stop_in),
        .o_directie_driverA  (o_dir_a),
        .o_directie_driverB  (o_dir_b),
        .o_factor_dc_driverA (o_dc_a),
        .o_factor_dc_driverB (o_dc_b),
        .o_count_ture        (o_count),
        .o_tact_count        (o_tact),
        .o_stop              (o_stop),
        .o_cursa_terminata   (o_done)
    );

    localparam int S_DCA = 0, S_DCB = 1, S_CNT = 2, S_TACT = 3, S_STOP = 4,
                   S_DONE = 5, S_DIRA = 6, S_DIRB = 7, S_PULSES = 8;

    function automatic logic [11:0] obs(int sel);
        case (sel)
            S_DCA:    return o_dc_a;
            S_DCB:    return o_dc_b;
            S_CNT:    return {4'h0, o_count};
            S_TACT:   return {11'h0, o_tact};
            S_STOP:   return {11'h0, o_stop};
            S_DONE:   return {11'h0, o_done};
            S_DIRA:   return {10'h0, o_dir_a};
            S_DIRB:   return {10'h0, o_dir_b};
            S_PULSES: return 12'(pulses);
            default:  return 12'hXXX;
        endcase
    endfunction

    task automatic expect_val(string tag, int sel, logic [11:0] v);
        sb.push_back('{tag: tag, sel: sel, exp: v});
    endtask

    task automatic check_all();
        exp_t        e;
        logic [11:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.sel);
            vectors++;
            assert (got === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_tact) pulses++;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic crossing();
        linie = 1'b1; ticks(4);
        linie = 1'b0; ticks(4);
    endtask

    task automatic start_race(logic [1:0] c);
        circuit = c; start = 1'b1; tick(); start = 1'b0;
    endtask

    // Motors off: zero duty, gated directions, brake light on.
    task automatic expect_off(string tag);
        expect_val({tag, "_dca"},  S_DCA,  12'h000);
        expect_val({tag, "_dcb"},  S_DCB,  12'h000);
        expect_val({tag, "_dira"}, S_DIRA, 12'h000);
        expect_val({tag, "_dirb"}, S_DIRB, 12'h000);
        expect_val({tag, "_stop"}, S_STOP, 12'h001);
    endtask

    logic [11:0] ramp_tbl [7];

    initial begin
        ramp_tbl = '{12'h000, 12'h000, 12'h400, 12'h400, 12'h800, 12'h800, 12'hC00};

        // Reset state
        ticks(2);
        expect_off("rst");
        expect_val("rst_cnt",  S_CNT,  12'h000);
        expect_val("rst_tact", S_TACT, 12'h000);
        expect_val("rst_done", S_DONE, 12'h000);
        check_all();
        rst = 1'b0;
        start = 1'b1; ticks(2); start = 1'b0;
        expect_off("start_c00");
        check_all();

        // 1: ramp 000/400/800/C00 then RUN
        start_race(2'b01);
        expect_val("ramp_stop", S_STOP, 12'h000);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            expect_val($sformatf("ramp%0d_a", i), S_DCA, ramp_tbl[i]);
            expect_val($sformatf("ramp%0d_b", i), S_DCB, ramp_tbl[i]);
            check_all();
        end
        dir_a = 2'b10; dir_b = 2'b11; #1;
        expect_val("run_dira", S_DIRA, 12'h002);
        expect_val("run_dirb", S_DIRB, 12'h003);
        stop_in = 1'b1; tick();
        expect_val("run_stop1", S_STOP, 12'h001);
        check_all();
        stop_in = 1'b0; tick();
        expect_val("run_stop0", S_STOP, 12'h000);
        check_all();

        // 2: debounce, lap limit, timed brake
        pulses = 0;
        linie = 1'b1; ticks(3); linie = 1'b0; tick();
        expect_val("short_cnt", S_CNT, 12'h000);
        expect_val("short_pul", S_PULSES, 12'h000);
        check_all();
        linie = 1'b1; ticks(10); linie = 1'b0; ticks(4);
        expect_val("long_cnt", S_CNT, 12'h001);
        expect_val("long_pul", S_PULSES, 12'h001);
        check_all();
        linie = 1'b1; ticks(4); linie = 1'b0;
        expect_val("lap2_cnt", S_CNT, 12'h002);
        expect_val("lap2_dc",  S_DCA, 12'hC00);
        expect_val("lap2_dir", S_DIRA, 12'h002);
        check_all();
        tick();
        expect_off("brake");
        expect_val("brake_done", S_DONE, 12'h000);
        check_all();
        ticks(7);
        expect_val("brake7_done", S_DONE, 12'h000);
        check_all();
        tick();
        expect_val("done_flag", S_DONE, 12'h001);
        expect_off("done");
        check_all();

        // 4: circuit change re-targets, circuit 00 clears
        circuit = 2'b00; tick();
        expect_val("clr_cnt",  S_CNT,  12'h000);
        expect_val("clr_done", S_DONE, 12'h000);
        check_all();
        start_race(2'b10);
        for (int i = 0; i < 5; i++) crossing();
        expect_val("c10_cnt", S_CNT, 12'h005);
        expect_val("c10_dc",  S_DCA, 12'hC00);
        check_all();
        circuit = 2'b01; tick();
        expect_off("retarget");
        check_all();
        ticks(8);
        expect_val("retarget_done", S_DONE, 12'h001);
        check_all();
        circuit = 2'b00; tick();
        expect_val("idle_cnt",  S_CNT,  12'h000);
        expect_val("idle_done", S_DONE, 12'h000);
        check_all();

        // 3: endurance saturates, never brakes
        pulses = 0;
        start_race(2'b11);
        for (int i = 0; i < 300; i++) crossing();
        expect_val("end_cnt",  S_CNT,    12'h0FF);
        expect_val("end_pul",  S_PULSES, 12'd300);
        expect_val("end_dc",   S_DCB,    12'hC00);
        expect_val("end_stop", S_STOP,   12'h000);
        expect_val("end_dir",  S_DIRA,   12'h002);
        check_all();

        // 5: acceptance edge collides with circuit 00
        pulses = 0;
        linie = 1'b1; ticks(3);
        circuit = 2'b00; tick(); tick();
        linie = 1'b0;
        expect_val("clash_cnt", S_CNT,    12'h000);
        expect_val("clash_pul", S_PULSES, 12'h000);
        expect_off("clash");
        check_all();

        // 6: reset mid-ramp, start ignored in RUN
        start_race(2'b01);
        ticks(4);
        expect_val("pre_rst_dc", S_DCA, 12'h800);
        check_all();
        rst = 1'b1; tick(); rst = 1'b0;
        expect_off("midrst");
        expect_val("midrst_cnt", S_CNT, 12'h000);
        check_all();
        tick();
        expect_val("post_rst_dc", S_DCA, 12'h000);
        check_all();
        start_race(2'b01);
        ticks(6);
        start = 1'b1; ticks(3); start = 1'b0;
        expect_val("rst_run_dc",  S_DCA,  12'hC00);
        expect_val("rst_run_dir", S_DIRB, 12'h003);
        expect_val("rst_run_cnt", S_CNT,  12'h000);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
